icap_reboot_ctl: RTL

- Sequences the Spartan-6 ICAP through a complete warm-boot (IPROG) command stream.
- Arbitrates between two reboot requesters:
  - the CPU, via a CSR-level pulse carrying a 24-bit flash address;
  - the front-panel button path, which selects the regular or rescue bitstream.
- Sits between the CSR/button logic and the ICAP_SPARTAN6 primitive and owns every ICAP pin.
- Includes a power-up holdoff before the first reconfiguration, a busy/done status and ICAP BUSY stall handling.

---
 rtl/icap_reboot_ctl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/icap_reboot_ctl.sv
// Warm-boot (IPROG) sequencer for the Spartan-6 ICAP with sw/button request arbitration.
// Optional button debounce: define ICAP_REBOOT_DEBOUNCE_EN.
module icap_reboot_ctl #(
    parameter int          HOLDOFF_W    = 20,
    parameter logic [23:0] REGULAR_ADDR = 24'h370000,
    parameter logic [23:0] RESCUE_ADDR  = 24'h050000,
    parameter logic [7:0]  OPCODE       = 8'h00
`ifdef ICAP_REBOOT_DEBOUNCE_EN
    ,
    parameter int          DEBOUNCE_W   = 20
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sw_req,
    input  logic [23:0] sw_addr,
    input  logic        btn_req,
    input  logic        btn_rescue,
    input  logic        icap_busy,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_d,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        ST_WAIT   = 4'd0,
        ST_IDLE   = 4'd1,
        ST_DUMMY  = 4'd2,
        ST_SYNC1  = 4'd3,
        ST_SYNC2  = 4'd4,
        ST_GEN1_C = 4'd5,
        ST_GEN1_D = 4'd6,
        ST_GEN2_C = 4'd7,
        ST_GEN2_D = 4'd8,
        ST_CMD    = 4'd9,
        ST_IPROG  = 4'd10,
        ST_NOP    = 4'd11,
        ST_DONE   = 4'd12
    } state_t;

    localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

    // ICAP expects each byte presented MSB-first on the LSB pin.
    function automatic logic [15:0] bit_swap(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    state_t                state_r, next_s, adv_s;
    logic [HOLDOFF_W-1:0]  hold_cnt_r;
    logic [1:0]            btn_sync_r, rescue_sync_r;
    logic                  btn_edge_s, btn_rescue_s;
    logic                  pend_r, accept_s;
    logic [23:0]           addr_r, accept_addr_s;
    logic [15:0]           word_s, d_s;
    logic                  in_seq_s, ce_n_s, busy_s, done_s;

    // Power-up holdoff counter, saturates once its MSB sets
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt_r <= '0;
        end else if (!hold_cnt_r[HOLDOFF_W-1]) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
        end
    end

    // Two-flop synchronizers for the raw button inputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_sync_r    <= 2'b00;
            rescue_sync_r <= 2'b00;
        end else begin
            btn_sync_r    <= {btn_sync_r[0], btn_req};
            rescue_sync_r <= {rescue_sync_r[0], btn_rescue};
        end
    end

`ifdef ICAP_REBOOT_DEBOUNCE_EN
    localparam logic [DEBOUNCE_W-1:0] DEB_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    logic [DEBOUNCE_W-1:0] deb_cnt_r;
    logic                  deb_tick_s, deb_tick_d_r;
    logic                  btn_deb_r, btn_deb_prev_r, rescue_deb_r;

    assign deb_tick_s = &deb_cnt_r;

    // Free-running tick counter; button levels are only sampled on a tick
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt_r      <= '0;
            deb_tick_d_r   <= 1'b0;
            btn_deb_r      <= 1'b0;
            btn_deb_prev_r <= 1'b0;
            rescue_deb_r   <= 1'b0;
        end else begin
            deb_cnt_r    <= deb_cnt_r + DEB_ONE;
            deb_tick_d_r <= deb_tick_s;
            if (deb_tick_s) begin
                btn_deb_r      <= btn_sync_r[1];
                btn_deb_prev_r <= btn_deb_r;
                rescue_deb_r   <= rescue_sync_r[1];
            end
        end
    end

    assign btn_edge_s   = deb_tick_d_r & btn_deb_r & ~btn_deb_prev_r;
    assign btn_rescue_s = rescue_deb_r;
`else
    logic btn_prev_r;

    // Previous synchronized button level for rising-edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_prev_r <= 1'b0;
        end else begin
            btn_prev_r <= btn_sync_r[1];
        end
    end

    assign btn_edge_s   = btn_sync_r[1] & ~btn_prev_r;
    assign btn_rescue_s = rescue_sync_r[1];
`endif

    // Request arbitration: first accepted request wins, sw beats btn on a tie
    always_comb begin
        accept_s      = 1'b0;
        accept_addr_s = addr_r;
        if ((state_r == ST_WAIT || state_r == ST_IDLE) && !pend_r) begin
            if (sw_req) begin
                accept_s      = 1'b1;
                accept_addr_s = sw_addr;
            end else if (btn_edge_s) begin
                accept_s      = 1'b1;
                accept_addr_s = btn_rescue_s ? RESCUE_ADDR : REGULAR_ADDR;
            end else begin
                accept_s      = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Pending request flag and latched flash address
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_r <= 1'b0;
            addr_r <= 24'h000000;
        end else if (accept_s) begin
            pend_r <= 1'b1;
            addr_r <= accept_addr_s;
        end else if (state_r == ST_IDLE && pend_r) begin
            pend_r <= 1'b0;
        end
    end

    // FSM next state and command word selection
    always_comb begin
        next_s   = state_r;
        adv_s    = state_r;
        word_s   = 16'hFFFF;
        in_seq_s = 1'b0;
        case (state_r)
            ST_WAIT:   next_s = hold_cnt_r[HOLDOFF_W-1] ? ST_IDLE : ST_WAIT;
            ST_IDLE:   next_s = pend_r ? ST_DUMMY : ST_IDLE;
            ST_DUMMY:  begin in_seq_s = 1'b1; word_s = 16'hFFFF;               adv_s = ST_SYNC1;  end
            ST_SYNC1:  begin in_seq_s = 1'b1; word_s = 16'hAA99;               adv_s = ST_SYNC2;  end
            ST_SYNC2:  begin in_seq_s = 1'b1; word_s = 16'h5566;               adv_s = ST_GEN1_C; end
            ST_GEN1_C: begin in_seq_s = 1'b1; word_s = 16'h3261;               adv_s = ST_GEN1_D; end
            ST_GEN1_D: begin in_seq_s = 1'b1; word_s = addr_r[15:0];           adv_s = ST_GEN2_C; end
            ST_GEN2_C: begin in_seq_s = 1'b1; word_s = 16'h3281;               adv_s = ST_GEN2_D; end
            ST_GEN2_D: begin in_seq_s = 1'b1; word_s = {OPCODE, addr_r[23:16]}; adv_s = ST_CMD;   end
            ST_CMD:    begin in_seq_s = 1'b1; word_s = 16'h30A1;               adv_s = ST_IPROG;  end
            ST_IPROG:  begin in_seq_s = 1'b1; word_s = 16'h000E;               adv_s = ST_NOP;    end
            ST_NOP:    begin in_seq_s = 1'b1; word_s = 16'h2000;               adv_s = ST_DONE;   end
            ST_DONE:   next_s = ST_DONE;
            default:   next_s = ST_WAIT;
        endcase
        if (in_seq_s && !icap_busy) begin
            next_s = adv_s;
        end else begin
            next_s = next_s;
        end
    end

    // Output values for the next cycle; a BUSY stall holds the data word
    always_comb begin
        ce_n_s = 1'b1;
        d_s    = 16'hFFFF;
        busy_s = 1'b0;
        done_s = 1'b0;
        if (in_seq_s) begin
            busy_s = 1'b1;
            if (!icap_busy) begin
                ce_n_s = 1'b0;
                d_s    = bit_swap(word_s);
            end else begin
                ce_n_s = 1'b1;
                d_s    = icap_d;
            end
        end else if (state_r == ST_DONE) begin
            busy_s = 1'b1;
            done_s = 1'b1;
        end else if (state_r == ST_IDLE && pend_r) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered ICAP pins and status
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b1;
            icap_d       <= 16'hFFFF;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            icap_ce_n    <= ce_n_s;
            icap_write_n <= ce_n_s;
            icap_d       <= d_s;
            busy         <= busy_s;
            done         <= done_s;
        end
    end

endmodule
